// File: rtl/mem_pkg.sv
// ============================================================================
// mem_pkg : shared size codes, FSM encoding and owner ids for mem_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package mem_pkg;

  localparam logic [1:0] MEM_BYTE = 2'd0;
  localparam logic [1:0] MEM_HALF = 2'd1;
  localparam logic [1:0] MEM_WORD = 2'd2;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_LS = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Size code 3 behaves as a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] sz);
    return (sz == 2'd3) ? MEM_WORD : sz;
  endfunction

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
    logic bad;
    bad = 1'b0;
    case (sz)
      MEM_HALF: bad = a[0];
      MEM_WORD: bad = (a != 2'b00);
      default:  bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arb_pick.sv
// ============================================================================
// mem_arb_pick : 2-input request picker (bit0 = IF, bit1 = LS), one-hot grant
// ARB_ROUND_ROBIN_EN selects rr-pointer tie-break instead of LS priority.
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_arb_pick
  import mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       rr_ptr,
  output logic [1:0] gnt
);

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt = (rr_ptr == OWNER_LS) ? 2'b10 : 2'b01;
    end else begin
      gnt = req;
    end
  end
`else
  logic unused_rr;
  assign unused_rr = rr_ptr;

  always_comb begin
    gnt = 2'b00;
    if (req[1]) begin
      gnt = 2'b10;
    end else if (req[0]) begin
      gnt = 2'b01;
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : shares a single-port RAM between instruction fetch and
// load/store; ARB_ROUND_ROBIN_EN enables alternating tie-break.
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_arbiter
  import mem_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int RAM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  output logic          if_err,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  input  logic [1:0]    ls_mem_sz,
  output logic          ls_gnt,
  output logic          ls_rvalid,
  output logic [DW-1:0] ls_rdata,
  output logic          ls_err,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_data_i,
  output logic [1:0]    ram_mem_sz,
  output logic          ram_we,
  input  logic [DW-1:0] ram_data_o
);

  localparam int CW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

  state_t        state, state_nxt;
  logic [CW-1:0] lat_cnt;
  logic          owner;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic [1:0]    sz_q;
  logic          we_q;
  logic          err_q;
  logic          rr_ptr;
  logic [1:0]    pick;
  logic          gnt_any;
  logic          gnt_mis;
  logic          last_busy;

  mem_arb_pick u_pick (
    .req    ({ls_req, if_req}),
    .rr_ptr (rr_ptr),
    .gnt    (pick)
  );

  // Grants are combinational but masked while reset is asserted.
  assign if_gnt    = (state == IDLE) && rst_n && pick[0];
  assign ls_gnt    = (state == IDLE) && rst_n && pick[1];
  assign gnt_any   = if_gnt || ls_gnt;
  assign gnt_mis   = ls_gnt ? misaligned(norm_size(ls_mem_sz), ls_addr[1:0])
                            : misaligned(MEM_WORD, if_addr[1:0]);
  assign last_busy = (lat_cnt == CW'(RAM_LAT - 1));

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= OWNER_IF;
    end else if ((state == IDLE) && if_req && ls_req) begin
      rr_ptr <= ls_gnt ? OWNER_IF : OWNER_LS;
    end
  end
`else
  assign rr_ptr = OWNER_IF;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      lat_cnt <= '0;
      owner   <= OWNER_IF;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      sz_q    <= MEM_BYTE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (gnt_any) begin
            owner   <= ls_gnt ? OWNER_LS : OWNER_IF;
            addr_q  <= ls_gnt ? ls_addr : if_addr;
            wdata_q <= (ls_gnt && ls_we) ? ls_wdata : '0;
            sz_q    <= ls_gnt ? norm_size(ls_mem_sz) : MEM_WORD;
            we_q    <= ls_gnt && ls_we && !gnt_mis;
            err_q   <= gnt_mis;
            rdata_q <= '0;
            lat_cnt <= '0;
          end
        end
        BUSY: begin
          if (last_busy) begin
            rdata_q <= we_q ? '0 : ram_data_o;
            lat_cnt <= '0;
          end else begin
            lat_cnt <= lat_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt  = state;
    ram_addr   = '0;
    ram_data_i = '0;
    ram_mem_sz = MEM_BYTE;
    ram_we     = 1'b0;
    if_rvalid  = 1'b0;
    if_rdata   = '0;
    if_err     = 1'b0;
    ls_rvalid  = 1'b0;
    ls_rdata   = '0;
    ls_err     = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_any) begin
          state_nxt = gnt_mis ? RESP : BUSY;
        end
      end
      BUSY: begin
        ram_addr   = addr_q;
        ram_data_i = wdata_q;
        ram_mem_sz = sz_q;
        // Write strobe only on the first BUSY cycle so each store lands once.
        ram_we     = we_q && (lat_cnt == '0);
        if (last_busy) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        state_nxt = IDLE;
        if (owner == OWNER_IF) begin
          if_rvalid = 1'b1;
          if_rdata  = rdata_q;
          if_err    = err_q;
        end else begin
          ls_rvalid = 1'b1;
          ls_rdata  = rdata_q;
          ls_err    = err_q;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter : directed bench for mem_arbiter (RAM_LAT=1) with byte RAM model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        ls_req;
  logic        ls_we;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [1:0]  ls_mem_sz;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [31:0] ls_rdata;
  logic        ls_err;
  logic [31:0] ram_addr;
  logic [31:0] ram_data_i;
  logic [1:0]  ram_mem_sz;
  logic        ram_we;
  logic [31:0] ram_data_o;

  int checks = 0;
  int errors = 0;
  int n;
  logic seen;
  logic mem_init;

  mem_arbiter #(.AW(32), .DW(32), .RAM_LAT(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .if_err     (if_err),
    .ls_req     (ls_req),
    .ls_we      (ls_we),
    .ls_addr    (ls_addr),
    .ls_wdata   (ls_wdata),
    .ls_mem_sz  (ls_mem_sz),
    .ls_gnt     (ls_gnt),
    .ls_rvalid  (ls_rvalid),
    .ls_rdata   (ls_rdata),
    .ls_err     (ls_err),
    .ram_addr   (ram_addr),
    .ram_data_i (ram_data_i),
    .ram_mem_sz (ram_mem_sz),
    .ram_we     (ram_we),
    .ram_data_o (ram_data_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Byte RAM: combinational read (one-cycle latency seen by the arbiter), write on edge.
  logic [7:0] mem [0:511];
  logic [8:0] ra;
  assign ra = ram_addr[8:0];

  always_comb begin
    case (ram_mem_sz)
      2'd0:    ram_data_o = {24'h0, mem[ra]};
      2'd1:    ram_data_o = {16'h0, mem[ra + 9'd1], mem[ra]};
      default: ram_data_o = {mem[ra + 9'd3], mem[ra + 9'd2], mem[ra + 9'd1], mem[ra]};
    endcase
  end

  always @(posedge clk) begin
    if (mem_init) begin
      for (int j = 0; j < 512; j++) mem[j] <= 8'(j) ^ 8'h5C;
    end else if (ram_we) begin
      mem[ra] <= ram_data_i[7:0];
      if (ram_mem_sz != 2'd0) mem[ra + 9'd1] <= ram_data_i[15:8];
      if (ram_mem_sz[1]) begin
        mem[ra + 9'd2] <= ram_data_i[23:16];
        mem[ra + 9'd3] <= ram_data_i[31:24];
      end
    end
  end

  function automatic logic [31:0] pat_word(input logic [31:0] a);
    logic [7:0] b0, b1, b2, b3;
    b0 = a[7:0] ^ 8'h5C;
    b1 = (a[7:0] + 8'd1) ^ 8'h5C;
    b2 = (a[7:0] + 8'd2) ^ 8'h5C;
    b3 = (a[7:0] + 8'd3) ^ 8'h5C;
    return {b3, b2, b1, b0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ls_access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [1:0] sz, input logic [31:0] exp_rd,
                           input logic exp_err, input int exp_lat);
    int cyc;
    int wep;
    logic got;
    @(posedge clk); #1;
    ls_req = 1'b1; ls_we = we; ls_addr = a; ls_wdata = wd; ls_mem_sz = sz;
    @(negedge clk);
    chk("ls_gnt", ls_gnt, 1);
    @(posedge clk); #1;
    ls_req = 1'b0;
    cyc = 0; wep = 0; got = 1'b0;
    while (!got && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (ram_we) begin
        wep++;
        chk("ram_addr_at_we", ram_addr, a);
        chk("ram_sz_at_we", 32'(ram_mem_sz), 32'((sz == 2'd3) ? 2'd2 : sz));
        chk("ram_data_at_we", ram_data_i, wd);
      end
      if (ls_rvalid) got = 1'b1;
    end
    chk("ls_latency", cyc, exp_lat);
    chk("ls_rdata", ls_rdata, exp_rd);
    chk("ls_err", 32'(ls_err), 32'(exp_err));
    chk("ls_we_pulses", wep, (we && !exp_err) ? 1 : 0);
  endtask

  task automatic if_access(input logic [31:0] a, input logic [31:0] exp_rd,
                           input logic exp_err, input int exp_lat);
    int cyc;
    int wep;
    logic got;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = a;
    @(negedge clk);
    chk("if_gnt", if_gnt, 1);
    @(posedge clk); #1;
    if_req = 1'b0;
    cyc = 0; wep = 0; got = 1'b0;
    while (!got && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (ram_we) wep++;
      if (if_rvalid) got = 1'b1;
    end
    chk("if_latency", cyc, exp_lat);
    chk("if_rdata", if_rdata, exp_rd);
    chk("if_err", 32'(if_err), 32'(exp_err));
    chk("if_we_pulses", wep, 0);
  endtask

  initial begin
    rst_n = 1'b0; mem_init = 1'b1;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_mem_sz = 2'd0;

    // Reset: every output low, even with a request pending.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ls_gnt", ls_gnt, 0);
    chk("rst_if_gnt", if_gnt, 0);
    chk("rst_rvalid", {if_rvalid, ls_rvalid, if_err, ls_err}, 0);
    chk("rst_rdata", if_rdata | ls_rdata, 0);
    chk("rst_ram", {ram_we, ram_mem_sz}, 0);
    chk("rst_ram_addr", ram_addr | ram_data_i, 0);
    ls_req = 1'b0; mem_init = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Store word then load it back.
    ls_access(1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 32'h0, 1'b0, 2);
    ls_access(1'b0, 32'h10, 32'h0, 2'd2, 32'hDEADBEEF, 1'b0, 2);

    // Contention: LS wins, IF granted three cycles later.
    @(posedge clk); #1;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h10; ls_mem_sz = 2'd2;
    if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk);
    chk("tie_ls_gnt", ls_gnt, 1);
    chk("tie_if_gnt", if_gnt, 0);
    @(posedge clk); #1;
    ls_req = 1'b0;
    n = 1; seen = 1'b0;
    @(negedge clk);
    while (!if_gnt && n < 10) begin
      if (ls_rvalid) begin
        seen = 1'b1;
        chk("tie_ls_lat", n, 2);
        chk("tie_ls_rdata", ls_rdata, 32'hDEADBEEF);
      end
      @(negedge clk);
      n++;
    end
    chk("tie_ls_rvalid_seen", 32'(seen), 1);
    chk("tie_if_wait", n, 3);
    @(posedge clk); #1;
    if_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("tie_if_rvalid", if_rvalid, 1);
    chk("tie_if_rdata", if_rdata, 32'hDEADBEEF);

    // Misaligned: granted, no RAM write, error response with zero data.
    ls_access(1'b1, 32'h13, 32'h1234, 2'd1, 32'h0, 1'b1, 1);
    ls_access(1'b0, 32'h13, 32'h0, 2'd1, 32'h0, 1'b1, 1);
    ls_access(1'b0, 32'h12, 32'h0, 2'd3, 32'h0, 1'b1, 1);
    if_access(32'h2, 32'h0, 1'b1, 1);

    // Byte store, single write strobe; read back by byte and aligned half.
    ls_access(1'b1, 32'h21, 32'hAB, 2'd0, 32'h0, 1'b0, 2);
    ls_access(1'b0, 32'h21, 32'h0, 2'd0, 32'hAB, 1'b0, 2);
    ls_access(1'b0, 32'h20, 32'h0, 2'd1, 32'hAB7C, 1'b0, 2);
    ls_access(1'b1, 32'h30, 32'hCAFEF00D, 2'd3, 32'h0, 1'b0, 2);
    ls_access(1'b0, 32'h30, 32'h0, 2'd2, 32'hCAFEF00D, 1'b0, 2);

    // Reset in the BUSY cycle of a store aborts it.
    @(posedge clk); #1;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h40; ls_wdata = 32'h12345678; ls_mem_sz = 2'd2;
    @(negedge clk);
    chk("abort_gnt", ls_gnt, 1);
    @(posedge clk); #1;
    ls_req = 1'b0;
    #1;
    chk("abort_we_before", ram_we, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_we_after", ram_we, 0);
    chk("abort_ram_addr", ram_addr | ram_data_i, 0);
    chk("abort_rvalid", {ls_rvalid, if_rvalid, ls_gnt, if_gnt}, 0);
    repeat (2) begin
      @(negedge clk);
      chk("abort_no_rvalid", {ls_rvalid, ls_err}, 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    ls_access(1'b0, 32'h40, 32'h0, 2'd2, 32'h1F1E1D1C, 1'b0, 2);

    // Back-to-back fetches with request held.
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h100;
    for (int i = 0; i < 64; i++) begin
      n = 0;
      @(negedge clk);
      while (!if_gnt && n < 8) begin
        @(negedge clk);
        n++;
      end
      chk("stream_gap", n, 0);
      @(posedge clk); #1;
      if (i < 63) if_addr = 32'h100 + 32'(4 * (i + 1));
      else if_req = 1'b0;
      @(negedge clk);
      chk("stream_early_rvalid", if_rvalid, 0);
      @(negedge clk);
      chk("stream_rvalid", if_rvalid, 1);
      chk("stream_rdata", if_rdata, pat_word(32'h100 + 32'(4 * i)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
